// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Round-robin arbiter and sequencer for one shared 8-bit
//             ADD/SUB/SHL datapath. Accepts one job at a time from up to
//             NREQ requesters, steps the accumulator through the operation
//             (or the three-step CHAIN), then returns the result together
//             with the owning requester ID.
//  Ports    : clk, rst_n         - clock (rising edge), async active-low reset
//             req_i              - per-requester job request (level)
//             op_a_i / op_b_i    - operands, 8 bits per requester
//             op_i               - opcode, 2 bits per requester
//                                  (00 ADD, 01 SUB, 10 SHL, 11 CHAIN)
//             grant_o            - one-hot, one-cycle job-accepted pulse
//             rsp_valid_o        - one-cycle result-valid pulse
//             rsp_id_o           - requester index owning the result
//             result_o           - job result, held until the next response
//             busy_o             - high whenever a job is in flight
//  Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_i,
    input  logic [8*NREQ-1:0]    op_a_i,
    input  logic [8*NREQ-1:0]    op_b_i,
    input  logic [2*NREQ-1:0]    op_i,
    output logic [NREQ-1:0]      grant_o,
    output logic                 rsp_valid_o,
    output logic [2:0]           rsp_id_o,
    output logic [7:0]           result_o,
    output logic                 busy_o
);

    localparam logic [1:0] C_OP_ADD   = 2'b00;
    localparam logic [1:0] C_OP_SUB   = 2'b01;
    localparam logic [1:0] C_OP_SHL   = 2'b10;
    localparam logic [1:0] C_OP_CHAIN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Per-requester views of the flat operand / opcode buses
    // ------------------------------------------------------------------
    logic [7:0] a_arr  [NREQ];
    logic [7:0] b_arr  [NREQ];
    logic [1:0] op_arr [NREQ];

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_unpack
            assign a_arr[g]  = op_a_i[8*g +: 8];
            assign b_arr[g]  = op_b_i[8*g +: 8];
            assign op_arr[g] = op_i[2*g +: 2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [2:0]        ptr_q,       ptr_d;
    logic [7:0]        a_q,         a_d;
    logic [7:0]        b_q,         b_d;
    logic [1:0]        op_q,        op_d;
    logic [2:0]        id_q,        id_d;
    logic [1:0]        step_q,      step_d;
    logic [7:0]        acc_q,       acc_d;
    logic [NREQ-1:0]   grant_q,     grant_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [2:0]        rsp_id_q,    rsp_id_d;
    logic [7:0]        result_q,    result_d;
    logic              busy_q,      busy_d;

    // ------------------------------------------------------------------
    // Round-robin winner: first set request bit searching ptr, ptr+1, ...
    // wrapping at NREQ. The candidate index is compared against each
    // requester number rather than used as an index so NREQ need not be
    // a power of two.
    // ------------------------------------------------------------------
    logic       win_found;
    logic [2:0] win_id;
    logic [3:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        cand      = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!win_found && (cand == 4'(j)) && req_i[j]) begin
                    win_found = 1'b1;
                    win_id    = 3'(j);
                end
            end
        end
    end

    // Operands of the winner only; other requesters' buses are ignored.
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [1:0] sel_op;

    always_comb begin
        sel_a  = 8'd0;
        sel_b  = 8'd0;
        sel_op = C_OP_ADD;
        for (int j = 0; j < NREQ; j++) begin
            if (win_id == 3'(j)) begin
                sel_a  = a_arr[j];
                sel_b  = b_arr[j];
                sel_op = op_arr[j];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared datapath step. Single ops finish in one step; CHAIN walks
    // ADD -> SUB b -> SHL through the accumulator using step_q.
    // All arithmetic is naturally modulo 256 at 8 bits.
    // ------------------------------------------------------------------
    logic [7:0] exec_val;
    logic       exec_last;

    always_comb begin
        exec_val  = acc_q;
        exec_last = 1'b1;
        unique case (op_q)
            C_OP_ADD: exec_val = a_q + b_q;
            C_OP_SUB: exec_val = a_q - b_q;
            C_OP_SHL: exec_val = {a_q[6:0], 1'b0};
            C_OP_CHAIN: begin
                unique case (step_q)
                    2'd0: begin
                        exec_val  = a_q + b_q;
                        exec_last = 1'b0;
                    end
                    2'd1: begin
                        exec_val  = acc_q - b_q;
                        exec_last = 1'b0;
                    end
                    default: begin
                        exec_val  = {acc_q[6:0], 1'b0};
                        exec_last = 1'b1;
                    end
                endcase
            end
            default: exec_val = acc_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic. grant and rsp_valid default low so each is a
    // single-cycle pulse; result and rsp_id hold between responses.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        step_d      = step_q;
        acc_d       = acc_q;
        grant_d     = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        result_d    = result_q;
        busy_d      = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    id_d    = win_id;
                    step_d  = 2'd0;
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
                    ptr_d   = (win_id == 3'(NREQ-1)) ? 3'd0 : (win_id + 3'd1);
                    busy_d  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                acc_d = exec_val;
                if (exec_last) begin
                    result_d    = exec_val;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    step_d      = 2'd0;
                    state_d     = ST_RESP;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs; reset drops any job in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            op_q        <= C_OP_ADD;
            id_q        <= 3'd0;
            step_q      <= 2'd0;
            acc_q       <= 8'd0;
            grant_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 3'd0;
            result_q    <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            grant_q     <= grant_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
        end
    end

    assign grant_o     = grant_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign result_o    = result_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_share_arbiter
//  Purpose  : Self-checking bench for alu_share_arbiter. A timestamp-based
//             transaction model predicts every output each cycle; directed
//             scenarios add literal expectations on top.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [8*N-1:0]   op_a = '0;
    logic [8*N-1:0]   op_b = '0;
    logic [2*N-1:0]   op = '0;
    logic [N-1:0]     grant_o;
    logic             rsp_valid_o;
    logic [2:0]       rsp_id_o;
    logic [7:0]       result_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.NREQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .op_i        (op),
        .grant_o     (grant_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_id_o    (rsp_id_o),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the opcode definitions, modulo 256.
    function automatic logic [7:0] alu_ref(input int a, input int b, input int opc);
        int r;
        case (opc)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a * 2;
            default: r = ((((a + b) % 256) - b) & 255) * 2;
        endcase
        return 8'(r);
    endfunction

    // ------------------------------------------------------------------
    // Transaction model: tracks edge numbers of capture / response / idle
    // ------------------------------------------------------------------
    int         m_e = 0;
    int         m_next_cap = 1;
    int         m_rsp_edge = -10;
    int         m_ptr = 0;
    logic [N-1:0] m_grant = '0;
    logic       m_rv = 1'b0;
    logic       m_busy = 1'b0;
    logic [2:0] m_id = '0;
    logic [7:0] m_res = '0;
    logic [7:0] m_pend_res = '0;
    logic [2:0] m_pend_id = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_e = 0; m_next_cap = 1; m_rsp_edge = -10; m_ptr = 0;
            m_grant = '0; m_rv = 1'b0; m_busy = 1'b0; m_id = '0; m_res = '0;
        end else begin
            int w;
            int lat;
            m_e++;
            m_grant = '0;
            m_rv    = 1'b0;
            if (m_e == m_rsp_edge) begin
                m_rv  = 1'b1;
                m_res = m_pend_res;
                m_id  = m_pend_id;
            end
            if (m_e == m_rsp_edge + 1) m_busy = 1'b0;
            if (m_e >= m_next_cap && req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                lat          = (op[2*w +: 2] == 2'b11) ? 3 : 1;
                m_pend_res   = alu_ref(int'(op_a[8*w +: 8]), int'(op_b[8*w +: 8]), int'(op[2*w +: 2]));
                m_pend_id    = 3'(w);
                m_grant      = N'(1) << w;
                m_busy       = 1'b1;
                m_rsp_edge   = m_e + lat;
                m_next_cap   = m_e + lat + 2;
                m_ptr        = (w + 1) % N;
            end
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        check("grant",     32'(grant_o),     32'(m_grant));
        check("rsp_valid", 32'(rsp_valid_o), 32'(m_rv));
        check("rsp_id",    32'(rsp_id_o),    32'(m_id));
        check("result",    32'(result_o),    32'(m_res));
        check("busy",      32'(busy_o),      32'(m_busy));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_job(input int idx, input int a, input int b, input int opc);
        op_a[8*idx +: 8] = 8'(a);
        op_b[8*idx +: 8] = 8'(b);
        op[2*idx +: 2]   = 2'(opc);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant_o != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("grant_timeout", 32'd0, 32'd1);
    endtask

    // One isolated job with a hand-computed expected result
    task automatic do_job(input int idx, input int a, input int b, input int opc, input int exp_res);
        bit ok;
        req = '0;
        set_job(idx, a, b, opc);
        req[idx] = 1'b1;
        wait_grant(ok);
        check("job_grant", 32'(grant_o), 32'(1 << idx));
        check("job_busy_grant", 32'(busy_o), 32'd1);
        req[idx] = 1'b0;
        if (opc == 3) begin
            tick(); check("chain_rv_e1", 32'(rsp_valid_o), 32'd0); check("chain_busy1", 32'(busy_o), 32'd1);
            tick(); check("chain_rv_e2", 32'(rsp_valid_o), 32'd0); check("chain_busy2", 32'(busy_o), 32'd1);
        end
        tick();
        check("job_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("job_result",    32'(result_o),    32'(exp_res));
        check("job_rsp_id",    32'(rsp_id_o),    32'(idx));
        check("job_busy_resp", 32'(busy_o),      32'd1);
        tick();
        check("job_idle_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        bit ok;
        int ng, last, cyc, gid;

        // Model pins: hand-computed values
        check("ref_sub",   32'(alu_ref(8'h10, 8'h20, 1)), 32'hF0);
        check("ref_chain", 32'(alu_ref(8'h81, 8'h05, 3)), 32'h02);
        check("ref_add",   32'(alu_ref(8'hFF, 8'h02, 0)), 32'h01);
        check("ref_shl",   32'(alu_ref(8'h80, 8'h37, 2)), 32'h00);

        tick(); tick();
        check("rst_grant",  32'(grant_o),     32'd0);
        check("rst_rv",     32'(rsp_valid_o), 32'd0);
        check("rst_id",     32'(rsp_id_o),    32'd0);
        check("rst_result", 32'(result_o),    32'd0);
        check("rst_busy",   32'(busy_o),      32'd0);
        rst_n = 1'b1;

        do_job(2, 8'h10, 8'h20, 1, 8'hF0);
        do_job(0, 8'h81, 8'h05, 3, 8'h02);
        do_job(3, 8'hFF, 8'h02, 0, 8'h01);
        do_job(1, 8'h80, 8'h37, 2, 8'h00);
        do_job(1, 8'h55, 8'h0A, 0, 8'h5F);
        tick(); tick();
        check("result_hold", 32'(result_o),    32'h5F);
        check("id_hold",     32'(rsp_id_o),    32'd1);
        check("rv_low_hold", 32'(rsp_valid_o), 32'd0);

        // req[1] raised while busy and held: granted at the first IDLE edge
        set_job(0, 8'h12, 8'h34, 3);
        req = 4'b0001;
        wait_grant(ok);
        set_job(1, 8'h01, 8'h02, 0);
        req = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("busy_req_nogrant", 32'(grant_o), 32'd0);
        end
        tick();
        check("busy_req_grant", 32'(grant_o), 32'b0010);
        req = '0;
        tick(); tick();

        // req[1] raised while busy, dropped before IDLE: never granted
        set_job(3, 8'h40, 8'h01, 3);
        req = 4'b1000;
        wait_grant(ok);
        req = '0;
        tick(); req[1] = 1'b1;
        tick();
        tick(); req[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("withdrawn_nogrant", 32'(grant_o), 32'd0);
        end

        // Reset during the second EXEC cycle of a CHAIN
        set_job(0, 8'h81, 8'h05, 3);
        set_job(1, 8'h03, 8'h04, 0);
        set_job(2, 8'h09, 8'h01, 1);
        req = 4'b0001;
        wait_grant(ok);
        req = 4'b0111;
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("midrst_grant",  32'(grant_o),     32'd0);
        check("midrst_rv",     32'(rsp_valid_o), 32'd0);
        check("midrst_id",     32'(rsp_id_o),    32'd0);
        check("midrst_result", 32'(result_o),    32'd0);
        check("midrst_busy",   32'(busy_o),      32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_grant", 32'(grant_o), 32'b0001);
        req = '0;
        for (int i = 0; i < 6; i++) tick();

        // Fairness: all requesters held high, single ops
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        set_job(0, 8'h11, 8'h22, 0);
        set_job(1, 8'h50, 8'h60, 1);
        set_job(2, 8'hC3, 8'h00, 2);
        set_job(3, 8'hF0, 8'h20, 0);
        req = 4'b1111;
        ng = 0; last = 0; cyc = 0;
        while (ng < 8 && cyc < 60) begin
            tick();
            cyc++;
            if (grant_o != '0) begin
                gid = -1;
                for (int i = 0; i < N; i++) if (grant_o[i]) gid = i;
                check("fair_order", 32'(gid), 32'(ng % N));
                if (ng > 0) check("fair_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                ng++;
            end
        end
        check("fair_count", 32'(ng), 32'd8);
        req = '0;
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(599) == 0) begin
                rst_n = 1'b0;
                tick(); tick();
                rst_n = 1'b1;
                req = '0;
                continue;
            end
            for (int i = 0; i < N; i++) begin
                if (grant_o[i]) begin
                    if ($urandom_range(3) == 0) begin
                        set_job(i, rnd8(), rnd8(), int'($urandom_range(3)));
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (req[i]) begin
                    if ($urandom_range(19) == 0) req[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    set_job(i, rnd8(), rnd8(), int'($urandom_range(3)));
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        for (int i = 0; i < 8; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic int rnd8();
        case ($urandom_range(7))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            3:       return 8'h01;
            default: return int'($urandom_range(255));
        endcase
    endfunction

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one 8-bit ADD/SUB/SHIFT datapath between up to NREQ requesters. It accepts one job at a time and steps the shared accumulator through the requested operation or chain. It then returns the result with the requester ID. It sits between the client engines and the common ALU datapath, and is the only block that drives that datapath.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- clk  in  1  clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester job request, level
- op_a  in  8*NREQ  operand A, slice i = [8*i+7:8*i]
- op_b  in  8*NREQ  operand B, same slicing
- op  in  2*NREQ  opcode: 00 ADD (a+b), 01 SUB (a-b), 10 SHL (a<<1), 11 CHAIN (((a+b)-b)<<1)
- grant  out  NREQ  one-hot, one-cycle pulse: job accepted
- rsp_valid  out  1  one-cycle pulse: result valid
- rsp_id  out  3  index of requester owning result
- result  out  8  job result
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, EXEC, RESP. Reset state IDLE.
- Outputs at reset: grant=0, rsp_valid=0, rsp_id=0, result=0, busy=0.
- Internal state at reset: RR pointer=0, accumulator=0, step counter=0.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set: winner is the first set bit searching ptr, ptr+1, … mod NREQ.
  - At that edge: capture op_a/op_b/op of the winner, register the winner ID, set grant[winner] for the next cycle, set ptr=(winner+1) mod NREQ, go to EXEC.
- EXEC, ADD/SUB/SHL: one edge computes the result into the accumulator, sets rsp_valid, go to RESP.
- EXEC, CHAIN: three edges (ADD, then SUB of captured b, then SHL), then go to RESP. rsp_valid is set on the third edge.
- RESP: rsp_valid, result and rsp_id are held for this one cycle; next edge go to IDLE and clear rsp_valid.
- Arithmetic rules:
  - All arithmetic is modulo 256.
  - ADD discards carry.
  - SUB wraps (0x00-0x01=0xFF).
  - SHL drops bit 7 and inserts 0 at bit 0.
- result and rsp_id hold their last value after RESP until the next response.
- Requester rules:
  - The requester holds req, operands and op stable until it sees its grant bit.
  - It deasserts req in the grant cycle unless it wants another job.
  - Dropping req before grant withdraws the job legally.
- req activity in EXEC/RESP is ignored; it is sampled only in IDLE.
- Operands and op of non-granted requesters are never sampled.
- NREQ < 8: rsp_id upper bits are 0.

## Timing
- E0 = capture edge in IDLE.
- grant pulse is high in the cycle after E0.
- rsp_valid is high in the cycle after E1 (single ops) or after E3 (CHAIN).
- Capture-to-response latency: 1 edge (single ops) or 3 edges (CHAIN).
- Minimum job spacing: 3 cycles (single ops), 5 cycles (CHAIN). The next capture is earliest at the edge after the RESP-to-IDLE edge.
- grant and rsp_valid never assert in the same cycle.
- At most one job is in flight.
- Reset asserted mid-job:
  - All outputs and state clear immediately (asynchronous).
  - The in-flight job is dropped with no rsp_valid.
  - ptr returns to 0.
- Deassertion of rst_n is synchronised externally; the first capture is possible at the first edge after release.

## Test plan
- Single SUB: req[2]=1 with a=0x10, b=0x20, op=01 -> grant=0100 one cycle, then rsp_valid with result=0xF0 and rsp_id=2, 1 cycle after grant.
- CHAIN: req[0] with a=0x81, b=0x05, op=11 -> rsp_valid 3 cycles after grant pulse, result=0x02, rsp_id=0; busy high from grant cycle through RESP.
- Fairness: all four req held high continuously, single-op jobs -> grants in order 0,1,2,3,0,… spaced 3 cycles apart.
- ADD wrap: req[3], a=0xFF, b=0x02, op=00 -> result=0x01. SHL: a=0x80, op=10 -> result=0x00.
- Requests during a job: req[1] asserted only while busy, then held -> no grant until IDLE, then granted at the first IDLE edge. req[1] dropped before IDLE -> no grant.
- Reset mid-CHAIN: rst_n low during the second EXEC cycle -> all outputs 0 immediately, no rsp_valid. After release, req[1] is granted before req[0]/req[2] only if it is the first set bit from ptr=0.
